// File: rtl/seq_booth_multiplier.sv
// Radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned; product valid WIDTH+1 edges after accept.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so no new accept while a result is pending.
module seq_booth_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);
    localparam logic [CW-1:0] STEP_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    // Accumulator carries one guard bit beyond the WIDTH+1 extended operand so acc +/- mcand never wraps.
    logic [WIDTH+1:0] acc;
    logic [WIDTH+1:0] mcand;
    logic [WIDTH+1:0] sum;
    logic [WIDTH+1:0] acc_nxt;
    logic [WIDTH:0]   q;
    logic [WIDTH:0]   q_nxt;
    logic             q_1;
    logic [CW-1:0]    step;
    logic             a_sign;
    logic             b_sign;
    logic             last;

    assign a_sign    = is_signed & a[WIDTH-1];
    assign b_sign    = is_signed & b[WIDTH-1];
    assign last      = (step == LAST_STEP);
    assign in_ready  = (state == IDLE);
    assign busy      = (state == RUN);
    assign out_valid = (state == DONE);

    always_comb begin
        sum = acc;
        case ({q[0], q_1})
            2'b01:   sum = acc + mcand;
            2'b10:   sum = acc - mcand;
            default: sum = acc;
        endcase
        acc_nxt = {sum[WIDTH+1], sum[WIDTH+1:1]};
        q_nxt   = {sum[0], q[WIDTH:1]};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            mcand   <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            step    <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= '0;
                        mcand <= {{2{a_sign}}, a};
                        q     <= {b_sign, b};
                        q_1   <= 1'b0;
                        step  <= '0;
                    end
                end
                RUN: begin
                    acc  <= acc_nxt;
                    q    <= q_nxt;
                    q_1  <= q[0];
                    step <= step + STEP_ONE;
                    if (last) begin
                        product <= {acc_nxt[WIDTH-2:0], q_nxt};
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Directed table plus handshake/reset sequences on a WIDTH=8 instance, random sweep, and exhaustive WIDTH=4 instance.
module tb_seq_booth_multiplier;
    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, is_signed, out_valid, out_ready, busy;
    logic [7:0]  a, b;
    logic [15:0] product;
    logic        in_valid_4, in_ready_4, is_signed_4, out_valid_4, out_ready_4, busy_4;
    logic [3:0]  a_4, b_4;
    logic [7:0]  product_4;

    int checks = 0;
    int failures = 0;
    logic watch_ov = 1'b0;
    logic ov_glitch = 1'b0;

    seq_booth_multiplier #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
        .out_ready(out_ready), .product(product), .busy(busy)
    );

    seq_booth_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_4), .in_ready(in_ready_4),
        .a(a_4), .b(b_4), .is_signed(is_signed_4), .out_valid(out_valid_4),
        .out_ready(out_ready_4), .product(product_4), .busy(busy_4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (watch_ov && out_valid) ov_glitch = 1'b1;
    end

    typedef struct {
        logic [7:0]  va;
        logic [7:0]  vb;
        logic        vs;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
        int xv, yv, p;
        xv = s ? int'($signed(x)) : int'(x);
        yv = s ? int'($signed(y)) : int'(y);
        p  = xv * yv;
        return p[15:0];
    endfunction

    function automatic logic [7:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic s);
        int xv, yv, p;
        xv = s ? int'($signed(x)) : int'(x);
        yv = s ? int'($signed(y)) : int'(y);
        p  = xv * yv;
        return p[7:0];
    endfunction

    // Called on the negedge after the accepting edge; counts edges until out_valid.
    task automatic wait_done(input bit disturb, output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            check("run_in_ready", {31'd0, in_ready}, 32'd0);
            if (disturb) begin
                in_valid  = 1'($urandom);
                a         = 8'($urandom);
                b         = 8'($urandom);
                is_signed = 1'($urandom);
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        check("done_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("taken_out_valid", {31'd0, out_valid}, 32'd0);
        check("taken_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_op8(input logic [7:0] va, input logic [7:0] vb, input logic vs,
                           input bit disturb, input bit take,
                           output logic [15:0] res, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1; a = va; b = vb; is_signed = vs;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("accept_busy", {31'd0, busy}, 32'd1);
        wait_done(disturb, lat);
        res = product;
        if (take) take_result();
    endtask

    task automatic run_op4(input logic [3:0] va, input logic [3:0] vb, input logic vs,
                           output logic [7:0] res, output int lat);
        int guard;
        guard = 0;
        while (!in_ready_4 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        in_valid_4 = 1'b1; a_4 = va; b_4 = vb; is_signed_4 = vs;
        @(posedge clk);
        @(negedge clk);
        in_valid_4 = 1'b0;
        lat = 0;
        while (!out_valid_4 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res = product_4;
        out_ready_4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_4 = 1'b0;
    endtask

    initial begin
        logic [15:0] res;
        logic [7:0]  res4;
        logic [7:0]  ra, rb;
        int          lat;

        vecs[0]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vecs[1]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[2]  = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
        vecs[3]  = '{8'h07, 8'hFD, 1'b1, 16'hFFEB};
        vecs[4]  = '{8'h80, 8'h02, 1'b0, 16'h0100};
        vecs[5]  = '{8'h7F, 8'h80, 1'b1, 16'hC080};
        vecs[6]  = '{8'h00, 8'hFF, 1'b0, 16'h0000};
        vecs[7]  = '{8'hFF, 8'h80, 1'b0, 16'h7F80};
        vecs[8]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        vecs[9]  = '{8'hFD, 8'hFD, 1'b1, 16'h0009};
        vecs[10] = '{8'h07, 8'hFD, 1'b0, 16'h06EB};
        vecs[11] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};

        rst = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; out_ready = 1'b0;
        in_valid_4 = 1'b0; a_4 = '0; b_4 = '0; is_signed_4 = 1'b0; out_ready_4 = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_product", {16'd0, product}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table; odd entries also wiggle the inputs while the multiply runs.
        for (int i = 0; i < 12; i++) begin
            run_op8(vecs[i].va, vecs[i].vb, vecs[i].vs, bit'(i % 2), 1'b1, res, lat);
            check($sformatf("vec%0d_product", i), {16'd0, res}, {16'd0, vecs[i].exp});
            check($sformatf("vec%0d_latency", i), lat, 32'd9);
        end

        // Hold the result against backpressure.
        run_op8(8'h07, 8'hFD, 1'b1, 1'b0, 1'b0, res, lat);
        check("hold_latency", lat, 32'd9);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_product", {16'd0, product}, 32'h0000FFEB);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        // in_valid during the taking DONE cycle must not be accepted there.
        in_valid = 1'b1; a = 8'h05; b = 8'h03; is_signed = 1'b0;
        take_result();
        check("b2b_no_accept_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_accept_busy", {31'd0, busy}, 32'd1);
        wait_done(1'b1, lat);
        check("b2b_product", {16'd0, product}, 32'h0000000F);
        check("b2b_latency", lat, 32'd9);
        take_result();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("idle_no_second_op", {30'd0, busy, out_valid}, 32'd0);
        end

        // Abort mid-run with reset between clock edges.
        watch_ov = 1'b1;
        ov_glitch = 1'b0;
        in_valid = 1'b1; a = 8'h80; b = 8'h80; is_signed = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_product", {16'd0, product}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        watch_ov = 1'b0;
        check("abort_no_out_valid", {31'd0, ov_glitch}, 32'd0);
        run_op8(8'hFD, 8'h07, 1'b1, 1'b0, 1'b1, res, lat);
        check("post_abort_product", {16'd0, res}, 32'h0000FFEB);
        check("post_abort_latency", lat, 32'd9);

        for (int i = 0; i < 2000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op8(ra, rb, 1'(i % 2), 1'b0, 1'b1, res, lat);
            check("sweep8_product", {16'd0, res}, {16'd0, ref8(ra, rb, 1'(i % 2))});
        end

        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    run_op4(4'(x), 4'(y), 1'(s), res4, lat);
                    check("exh4_product", {24'd0, res4}, {24'd0, ref4(4'(x), 4'(y), 1'(s))});
                    check("exh4_latency", lat, 32'd5);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
